// File: rtl/array_eyeriss_seq.sv
// Control sequencer for an Eyeriss-style uGEMM-rate PE array: weight load, skewed MAC windows,
// flush and skewed output drain. Define ARRAY_SEQ_PERF_CNT_EN to add the o_perf_cyc busy counter.
module array_eyeriss_seq #(
    parameter int unsigned HEIGHT = 12,
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned IWIDTH = 16,
    parameter int unsigned KWIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [KWIDTH-1:0] i_k_cnt,
    input  logic [IWIDTH-1:0] i_mac_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_en_w,
    output logic [WIDTH-1:0]  o_clr_w,
    output logic [HEIGHT-1:0] o_en_i,
    output logic [HEIGHT-1:0] o_clr_i,
    output logic [HEIGHT-1:0] o_mac_done,
    output logic [WIDTH-1:0]  o_en_o,
    output logic [WIDTH-1:0]  o_clr_o,
    output logic              o_ofm_vld
`ifdef ARRAY_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       o_perf_cyc
`endif
);

    localparam int unsigned CW = $clog2(HEIGHT + WIDTH + 1);
    localparam logic [IWIDTH-1:0] MAX_LEN = {1'b1, {(IWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StCompute,
        StFlush,
        StDrain,
        StDone
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [IWIDTH-1:0] r_win, w_win_nxt;
    logic [KWIDTH-1:0] r_vec, w_vec_nxt;
    logic [KWIDTH-1:0] r_k, w_k_nxt;
    logic [IWIDTH-1:0] r_len, w_len_nxt;
    logic [IWIDTH-1:0] w_len_conv;

    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [WIDTH-1:0]  r_en_w, w_en_w_nxt;
    logic [WIDTH-1:0]  r_clr_w, w_clr_w_nxt;
    logic [HEIGHT-1:0] r_en_i, r_clr_i, r_mac_done;
    logic              w_en_i0, w_clr_i0, w_mac_done0;
    logic [WIDTH-1:0]  r_en_o, w_en_o_nxt;
    logic [WIDTH-1:0]  r_clr_o, w_clr_o_nxt;
    logic              r_ofm_vld;

    // Zero-length windows run as one cycle; oversized windows clamp to the rate-code maximum.
    assign w_len_conv = (i_mac_len == '0)     ? IWIDTH'(1) :
                        (i_mac_len > MAX_LEN) ? MAX_LEN    : i_mac_len;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_win_nxt   = r_win;
        w_vec_nxt   = r_vec;
        w_k_nxt     = r_k;
        w_len_nxt   = r_len;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StLoadW;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = i_k_cnt;
                    w_len_nxt   = w_len_conv;
                end
            end
            StLoadW: begin
                if (r_cnt == CW'(HEIGHT)) begin
                    w_cnt_nxt   = '0;
                    w_win_nxt   = '0;
                    w_vec_nxt   = '0;
                    w_state_nxt = (r_k == '0) ? StDrain : StCompute;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            StCompute: begin
                // Nested window/vector counters keep k*L from overflowing.
                if (r_win == r_len - IWIDTH'(1)) begin
                    w_win_nxt = '0;
                    if (r_vec == r_k - KWIDTH'(1)) begin
                        w_vec_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (HEIGHT > 1) ? StFlush : StDrain;
                    end else begin
                        w_vec_nxt = r_vec + KWIDTH'(1);
                    end
                end else begin
                    w_win_nxt = r_win + IWIDTH'(1);
                end
            end
            StFlush: begin
                if (r_cnt == CW'(HEIGHT - 2)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StDrain;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            StDrain: begin
                if (r_cnt == CW'(HEIGHT + WIDTH - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StDone;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so every control line leaves a flop.
    always_comb begin
        w_busy_nxt  = (w_state_nxt != StIdle) && (w_state_nxt != StDone);
        w_done_nxt  = (w_state_nxt == StDone);
        w_clr_w_nxt = {WIDTH{(w_state_nxt == StLoadW) && (w_cnt_nxt == '0)}};
        w_en_w_nxt  = {WIDTH{(w_state_nxt == StLoadW) && (w_cnt_nxt != '0)}};
        w_en_i0     = (w_state_nxt == StCompute);
        w_clr_i0    = w_en_i0 && (w_win_nxt == '0);
        w_mac_done0 = w_en_i0 && (w_win_nxt == w_len_nxt - IWIDTH'(1));
        w_en_o_nxt  = '0;
        w_clr_o_nxt = '0;
        for (int w = 0; w < WIDTH; w++) begin
            w_en_o_nxt[w]  = (w_state_nxt == StDrain) && (w_cnt_nxt >= CW'(w)) &&
                             (w_cnt_nxt < CW'(w + HEIGHT));
            w_clr_o_nxt[w] = (w_state_nxt == StDrain) && (w_cnt_nxt == CW'(w + HEIGHT));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_win   <= '0;
            r_vec   <= '0;
            r_k     <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_win   <= w_win_nxt;
            r_vec   <= w_vec_nxt;
            r_k     <= w_k_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_en_w     <= '0;
            r_clr_w    <= '0;
            r_en_i     <= '0;
            r_clr_i    <= '0;
            r_mac_done <= '0;
            r_en_o     <= '0;
            r_clr_o    <= '0;
            r_ofm_vld  <= 1'b0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_en_w        <= w_en_w_nxt;
            r_clr_w       <= w_clr_w_nxt;
            r_en_i[0]     <= w_en_i0;
            r_clr_i[0]    <= w_clr_i0;
            r_mac_done[0] <= w_mac_done0;
            // Row h sees the row-0 stream h cycles later.
            for (int h = 1; h < HEIGHT; h++) begin
                r_en_i[h]     <= r_en_i[h-1];
                r_clr_i[h]    <= r_clr_i[h-1];
                r_mac_done[h] <= r_mac_done[h-1];
            end
            r_en_o        <= w_en_o_nxt;
            r_clr_o       <= w_clr_o_nxt;
            r_ofm_vld     <= w_en_o_nxt[0];
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_en_w     = r_en_w;
    assign o_clr_w    = r_clr_w;
    assign o_en_i     = r_en_i;
    assign o_clr_i    = r_clr_i;
    assign o_mac_done = r_mac_done;
    assign o_en_o     = r_en_o;
    assign o_clr_o    = r_clr_o;
    assign o_ofm_vld  = r_ofm_vld;

`ifdef ARRAY_SEQ_PERF_CNT_EN
    logic        w_accept;
    logic [31:0] r_perf;

    assign w_accept = (r_state == StIdle) && i_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (r_busy) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign o_perf_cyc = r_perf;
`endif

endmodule

// File: tb/tb_array_eyeriss_seq.sv
// Randomised directed bench for array_eyeriss_seq; expected waveforms come from closed-form
// cycle formulas of the tile schedule rather than from any state machine.
module tb_array_eyeriss_seq;

    localparam int H    = 4;
    localparam int W    = 3;
    localparam int IW   = 6;
    localparam int KW   = 8;
    localparam int MAXL = 1 << (IW - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_cnt;
    logic [IW-1:0] mac_len;
    logic          busy, done, ofm_vld;
    logic [W-1:0]  en_w, clr_w, en_o, clr_o;
    logic [H-1:0]  en_i, clr_i, mac_done;
`ifdef ARRAY_SEQ_PERF_CNT_EN
    logic [31:0]   perf_cyc;
`endif

    int total = 0;
    int bad   = 0;
    int md_cnt[H];

    always #5 clk = ~clk;

    array_eyeriss_seq #(
        .HEIGHT(H),
        .WIDTH (W),
        .IWIDTH(IW),
        .KWIDTH(KW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_k_cnt   (k_cnt),
        .i_mac_len (mac_len),
        .o_busy    (busy),
        .o_done    (done),
        .o_en_w    (en_w),
        .o_clr_w   (clr_w),
        .o_en_i    (en_i),
        .o_clr_i   (clr_i),
        .o_mac_done(mac_done),
        .o_en_o    (en_o),
        .o_clr_o   (clr_o),
        .o_ofm_vld (ofm_vld)
`ifdef ARRAY_SEQ_PERF_CNT_EN
        ,
        .o_perf_cyc(perf_cyc)
`endif
    );

    task automatic chk(input string tag, input int t, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    function automatic int eff_len(input int ml);
        if (ml == 0) return 1;
        if (ml > MAXL) return MAXL;
        return ml;
    endfunction

    function automatic int done_cycle(input int k, input int len);
        if (k == 0) return 2 * H + W + 2;
        return 3 * H + k * len + W + 1;
    endfunction

    // Expected outputs at cycle t after a start accepted at cycle 0.
    task automatic check_cycle(input int t, input int k, input int len);
        int           tdone, ds, d, u;
        logic [H-1:0] e_en_i, e_clr_i, e_md;
        logic [W-1:0] e_en_o, e_clr_o, e_en_w, e_clr_w;
        tdone   = done_cycle(k, len);
        ds      = (k > 0) ? 2 * H + 1 + k * len : H + 2;
        d       = t - ds;
        e_en_i  = '0;
        e_clr_i = '0;
        e_md    = '0;
        for (int h = 0; h < H; h++) begin
            u = t - h - (H + 2);
            if (u >= 0 && u < k * len) begin
                e_en_i[h]  = 1'b1;
                e_clr_i[h] = (u % len) == 0;
                e_md[h]    = (u % len) == len - 1;
            end
        end
        for (int w = 0; w < W; w++) begin
            e_en_o[w]  = (d >= w) && (d < w + H);
            e_clr_o[w] = (d == w + H);
        end
        e_clr_w = (t == 1) ? '1 : '0;
        e_en_w  = (t >= 2 && t <= H + 1) ? '1 : '0;
        chk("busy",     t, 32'(busy),     32'(t >= 1 && t < tdone));
        chk("done",     t, 32'(done),     32'(t == tdone));
        chk("clr_w",    t, 32'(clr_w),    32'(e_clr_w));
        chk("en_w",     t, 32'(en_w),     32'(e_en_w));
        chk("en_i",     t, 32'(en_i),     32'(e_en_i));
        chk("clr_i",    t, 32'(clr_i),    32'(e_clr_i));
        chk("mac_done", t, 32'(mac_done), 32'(e_md));
        chk("en_o",     t, 32'(en_o),     32'(e_en_o));
        chk("clr_o",    t, 32'(clr_o),    32'(e_clr_o));
        chk("ofm_vld",  t, 32'(ofm_vld),  32'(e_en_o[0]));
`ifdef ARRAY_SEQ_PERF_CNT_EN
        chk("perf_cyc", t, perf_cyc, 32'(((t < tdone) ? t : tdone) - 1));
`endif
    endtask

    task automatic check_zero(input string tag, input int t);
        chk({tag, "_busy"},     t, 32'(busy),     32'd0);
        chk({tag, "_done"},     t, 32'(done),     32'd0);
        chk({tag, "_en_w"},     t, 32'(en_w),     32'd0);
        chk({tag, "_clr_w"},    t, 32'(clr_w),    32'd0);
        chk({tag, "_en_i"},     t, 32'(en_i),     32'd0);
        chk({tag, "_clr_i"},    t, 32'(clr_i),    32'd0);
        chk({tag, "_mac_done"}, t, 32'(mac_done), 32'd0);
        chk({tag, "_en_o"},     t, 32'(en_o),     32'd0);
        chk({tag, "_clr_o"},    t, 32'(clr_o),    32'd0);
        chk({tag, "_ofm_vld"},  t, 32'(ofm_vld),  32'd0);
`ifdef ARRAY_SEQ_PERF_CNT_EN
        chk({tag, "_perf"},     t, perf_cyc,      32'd0);
`endif
    endtask

    // Called at a negedge while idle; returns at a negedge.  abort_at>0 stops at that cycle.
    task automatic run_tile(input int k, input int ml, input int abort_at, input bit inject);
        int len, tdone;
        len   = eff_len(ml);
        tdone = done_cycle(k, len);
        for (int h = 0; h < H; h++) md_cnt[h] = 0;
        start   = 1'b1;
        k_cnt   = KW'(k);
        mac_len = IW'(ml);
        @(negedge clk);
        for (int t = 1; t <= tdone + 2; t++) begin
            check_cycle(t, k, len);
            for (int h = 0; h < H; h++) if (mac_done[h]) md_cnt[h]++;
            if (t == abort_at) return;
            // Inputs scrambled every cycle: latched values must not follow them.
            k_cnt   = KW'($urandom);
            mac_len = IW'($urandom);
            start   = inject && (t <= tdone) && ($urandom_range(0, 2) == 0);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        k_cnt   = '0;
        mac_len = '0;
        repeat (2) @(negedge clk);
        check_zero("reset", 0);
        rst = 1'b0;
        @(negedge clk);

        run_tile(2, 4, 0, 1'b0);
        run_tile(3, 0, 0, 1'b0);
        run_tile(3, 1, 0, 1'b0);
        run_tile(2, MAXL + 5, 0, 1'b0);
        for (int h = 0; h < H; h++) chk("sat_md_count", h, 32'(md_cnt[h]), 32'd2);
        run_tile(0, 7, 0, 1'b0);
        run_tile(2, 3, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_tile(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 0, 1'b1);
        end

        // Reset in the middle of COMPUTE, away from any clock edge.
        run_tile(3, 5, H + 2 + 4, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst", 0);
        repeat (2) @(negedge clk);
        check_zero("rst_hold", 0);
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_rst", 0);

        run_tile(2, 4, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("idle_busy", 0, 32'(busy), 32'd0);
`ifdef ARRAY_SEQ_PERF_CNT_EN
        chk("perf_hold", 0, perf_cyc, 32'd23);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/array_eyeriss_seq.md
# array_eyeriss_seq

Parametrised control sequencer for the next-generation Eyeriss-style uGEMM-rate array. It produces every per-row and per-column control vector the PE grid consumes (en_i/clr_i/mac_done, en_w/clr_w, en_o/clr_o) from a single start/done handshake. It adds a runtime MAC window length (rate-coded bitstream truncation), a runtime reduction depth, and an output drain phase. It sits between the tile scheduler and the array, replacing hand-driven control vectors.

## Interface
- HEIGHT, 12, array rows
- WIDTH, 14, array columns
- IWIDTH, 16, operand width; maximum MAC window is 2^(IWIDTH-1) cycles
- KWIDTH, 16, width of the reduction-depth count
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- k_cnt  in  KWIDTH  number of ifm vectors in the tile; latched on start
- mac_len  in  IWIDTH  cycles per MAC window; latched on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at tile end
- en_w, clr_w  out  WIDTH  weight load controls
- en_i, clr_i, mac_done  out  HEIGHT  per-row input controls, row-skewed
- en_o, clr_o  out  WIDTH  per-column output drain controls, column-skewed
- ofm_vld  out  1  column-0 array output valid, equal to en_o[0]

## Operation
- FSM states: IDLE, LOAD_W, COMPUTE, FLUSH, DRAIN, DONE. All outputs are registered.
- IDLE
  - start=1 latches k_cnt and mac_len and moves to LOAD_W.
  - start is ignored in every other state; no queueing.
- mac_len conversion when latched:
  - 0 → 1.
  - Values above 2^(IWIDTH-1) saturate to 2^(IWIDTH-1).
- LOAD_W (HEIGHT+1 cycles)
  - First cycle: clr_w = all ones.
  - Next HEIGHT cycles: en_w = all ones, so weights shift down every column.
- COMPUTE (k_cnt × L cycles, L = latched mac_len)
  - Base row-0 stream: en_i[0] = 1 on every cycle.
  - clr_i[0] = 1 on the first cycle of each window.
  - mac_done[0] = 1 on the last cycle of each window.
  - When L=1, clr_i[0] and mac_done[0] are both high in the same cycle.
  - k_cnt = 0 skips COMPUTE and FLUSH and goes directly to DRAIN.
- Row skew: row h outputs equal the row-0 base stream delayed by h cycles, implemented as a shift register of HEIGHT-1 stages per signal.
- FLUSH (HEIGHT-1 cycles)
  - The base stream is 0 while the skew registers empty.
  - Skipped when HEIGHT=1.
- DRAIN (HEIGHT+WIDTH cycles), drain counter d = 0..HEIGHT+WIDTH-1:
  - en_o[w] = 1 when w ≤ d < w+HEIGHT.
  - clr_o[w] = 1 when d = w+HEIGHT, after that column has shifted out.
- DONE: one cycle, done=1 and busy=0, then IDLE. start is accepted again in the following IDLE cycle.
- Reset, at any time including mid-tile:
  - State returns to IDLE.
  - Counters, skew registers and all outputs clear to 0.
  - The next start begins a full new sequence.

## Timing
- start accepted at cycle 0. busy rises at cycle 1, together with clr_w.
- en_w is high in cycles 2..HEIGHT+1. en_i[0] rises in cycle HEIGHT+2.
- Last mac_done[HEIGHT-1] occurs at cycle HEIGHT+1+k·L+HEIGHT-1.
- DRAIN starts at the cycle after that.
- done asserts at cycle T = 2·HEIGHT + k·L + HEIGHT + WIDTH + 1 (k ≥ 1).
- done asserts at cycle HEIGHT+2+HEIGHT+WIDTH when k = 0.
- Counters are sized so that k·L does not overflow: KWIDTH + IWIDTH bits for the total, or nested window/vector counters.

## Configuration
- ARRAY_SEQ_PERF_CNT_EN defined:
  - Adds output perf_cyc (32 bits).
  - perf_cyc counts cycles with busy=1 and holds its value after done until the next accepted start.
  - Cleared by reset.
- Without the macro, the port and the counter are absent, and the remaining behaviour is identical.

## Test plan
- HEIGHT=4, WIDTH=3, k_cnt=2, mac_len=4, start at cycle 0:
  - clr_w at cycle 1; en_w in cycles 2–5.
  - mac_done[0] at cycles 9 and 13; mac_done[3] at cycles 12 and 16.
  - en_o[2] high in cycles 19–22; done at cycle 24.
- mac_len=0 and mac_len=1 (k_cnt=3): every window is 1 cycle, and clr_i[h] and mac_done[h] are both high in the same cycle for each row.
- mac_len=2^(IWIDTH-1)+5: window length saturates to 2^(IWIDTH-1); verify exactly k_cnt mac_done pulses per row.
- k_cnt=0: no en_i activity; DRAIN follows LOAD_W directly; done at cycle 2·HEIGHT+WIDTH+2.
- start pulses during busy are ignored; rst asserted mid-COMPUTE clears all outputs and busy asynchronously; a fresh start after reset reproduces the first scenario's cycle numbers exactly.
- With ARRAY_SEQ_PERF_CNT_EN defined, after the first scenario perf_cyc = 23 and holds that value while idle.
